// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the fetch, decode and hazard stages.
//   XLEN        : datapath / address width
//   NOP_INSTR   : instruction word loaded into a squashed pipeline register
//   INSTR_BYTES : byte size of one instruction (PC increment)
//   if_state_t  : fetch-stage run state
//   pc_sel_t    : next-PC mux select
//   ifid_op_t   : IF/ID register update action
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } if_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_t;

    // Clear the byte-offset bits so the PC always points at a whole word.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(INSTR_BYTES) - XLEN'(1));
    endfunction

endpackage : cpu_pkg

// File: rtl/pc_reg.sv
// ----------------------------------------------------------------------------
// pc_reg
// Program counter register with its next-PC mux.
//   clk_i    : clock, rising edge
//   rst_i    : async active-low reset, loads RESET_PC
//   sel      : PC_HOLD / PC_INC / PC_REDIRECT
//   target   : redirect address (word-aligned here)
//   pc       : current PC
//   pc_plus4 : PC + INSTR_BYTES, wrapping modulo 2^XLEN
// ----------------------------------------------------------------------------
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  pc_sel_t         sel,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = align_word(RESET_PC);

    logic [XLEN-1:0] pc_next;

    // Natural XLEN-bit overflow gives the required wrap 0xFFFF_FFFC -> 0.
    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_INC:      pc_next = pc_plus4;
            PC_REDIRECT: pc_next = align_word(target);
            default:     pc_next = pc;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc <= RESET_PC_ALIGNED;
        end else begin
            pc <= pc_next;
        end
    end

endmodule : pc_reg

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: PC, IF/ID pipeline register, run FSM and
// saturating stall/flush event counters.
//   clk_i, rst_i  : clock (rising edge) and async active-low reset
//   start_i       : run enable; low parks the stage in IDLE
//   stall_i       : freeze PC and IF/ID (highest priority in RUN)
//   flush_i       : redirect to target_i and squash IF/ID
//   target_i      : redirect address, sampled with flush_i
//   imem_addr_o   : instruction memory byte address (= pc_o)
//   imem_instr_i  : instruction word read combinationally at imem_addr_o
//   pc_o          : current PC
//   ifid_pc_o     : IF/ID PC+4
//   ifid_instr_o  : IF/ID instruction
//   ifid_valid_o  : IF/ID holds a real instruction
//   stall_cnt_o   : applied stall cycles, saturating
//   flush_cnt_o   : applied flushes, saturating
//
// state | meaning
// IDLE  | PC held, bubbles into IF/ID, stall/flush ignored
// RUN   | fetching; stall > flush > normal fetch each cycle
// ----------------------------------------------------------------------------
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if_state_t       state;
    if_state_t       state_next;
    pc_sel_t         pc_sel;
    ifid_op_t        ifid_op;
    logic            stall_inc;
    logic            flush_inc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sel      (pc_sel),
        .target   (target_i),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign pc_o        = pc;
    assign imem_addr_o = pc;

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i)  state_next = RUN;
            RUN:     if (!start_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: per-cycle actions. A flush coinciding with a stall is dropped;
    // the hazard unit keeps flush_i asserted until the stall clears.
    always_comb begin
        pc_sel    = PC_HOLD;
        ifid_op   = IFID_BUBBLE;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state)
            RUN: begin
                if (stall_i) begin
                    pc_sel    = PC_HOLD;
                    ifid_op   = IFID_HOLD;
                    stall_inc = 1'b1;
                end else if (flush_i) begin
                    pc_sel    = PC_REDIRECT;
                    ifid_op   = IFID_BUBBLE;
                    flush_inc = 1'b1;
                end else begin
                    pc_sel    = PC_INC;
                    ifid_op   = IFID_LOAD;
                end
            end
            default: begin
                pc_sel  = PC_HOLD;
                ifid_op = IFID_BUBBLE;
            end
        endcase
    end

    // IF/ID pipeline register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_pc_o    <= '0;
            ifid_instr_o <= NOP_INSTR;
            ifid_valid_o <= 1'b0;
        end else begin
            case (ifid_op)
                IFID_LOAD: begin
                    ifid_pc_o    <= pc_plus4;
                    ifid_instr_o <= imem_instr_i;
                    ifid_valid_o <= 1'b1;
                end
                IFID_BUBBLE: begin
                    ifid_pc_o    <= '0;
                    ifid_instr_o <= NOP_INSTR;
                    ifid_valid_o <= 1'b0;
                end
                default: begin
                    ifid_pc_o    <= ifid_pc_o;
                    ifid_instr_o <= ifid_instr_o;
                    ifid_valid_o <= ifid_valid_o;
                end
            endcase
        end
    end

    // Saturating event counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_inc && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_o != CNT_MAX)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule : if_stage

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: a behavioural model compared every cycle,
// directed scenarios with literal expectations, randomized traffic, and a
// second instance (RESET_PC = 0xFFFF_FFFC, CNT_W = 3) for wrap and saturation.
// ----------------------------------------------------------------------------
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A (defaults) ----------------
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] imem_addr, imem_instr, pc, ifid_pc, ifid_instr;
    logic        ifid_valid;
    logic [31:0] stall_cnt, flush_cnt;

    assign imem_instr = mem_word(imem_addr);

    if_stage dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall),
        .flush_i(flush), .target_i(target), .imem_addr_o(imem_addr),
        .imem_instr_i(imem_instr), .pc_o(pc), .ifid_pc_o(ifid_pc),
        .ifid_instr_o(ifid_instr), .ifid_valid_o(ifid_valid),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // ---------------- instance B (wrap / saturation) ----------------
    logic        b_rst_n = 1'b0;
    logic        b_start = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
    logic [31:0] b_target = '0;
    logic [31:0] b_addr, b_instr, b_pc, b_ifid_pc, b_ifid_instr;
    logic        b_valid;
    logic [2:0]  b_scnt, b_fcnt;

    assign b_instr = mem_word(b_addr);

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(3)) dut_b (
        .clk_i(clk), .rst_i(b_rst_n), .start_i(b_start), .stall_i(b_stall),
        .flush_i(b_flush), .target_i(b_target), .imem_addr_o(b_addr),
        .imem_instr_i(b_instr), .pc_o(b_pc), .ifid_pc_o(b_ifid_pc),
        .ifid_instr_o(b_ifid_instr), .ifid_valid_o(b_valid),
        .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    // ---------------- behavioural model of instance A ----------------
    bit          m_run = 0;
    logic [31:0] m_pc = 32'h0, m_ifid_pc = 32'h0, m_ifid_instr = 32'h0;
    bit          m_valid = 0;
    logic [31:0] m_scnt = 32'h0, m_fcnt = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = 32'h0;
            m_valid = 0; m_scnt = 32'h0; m_fcnt = 32'h0;
        end else if (!m_run) begin
            m_ifid_pc = 32'h0; m_ifid_instr = 32'h0; m_valid = 0;
            m_run = start;
        end else begin
            if (stall) begin
                if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            end else if (flush) begin
                m_pc = {target[31:2], 2'b00};
                m_ifid_pc = 32'h0; m_ifid_instr = 32'h0; m_valid = 0;
                if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
            end else begin
                m_ifid_instr = mem_word(m_pc);
                m_pc = m_pc + 32'd4;
                m_ifid_pc = m_pc;
                m_valid = 1;
            end
            m_run = start;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_pc", pc, m_pc);
            check("m_imem_addr", imem_addr, m_pc);
            check("m_ifid_pc", ifid_pc, m_ifid_pc);
            check("m_ifid_instr", ifid_instr, m_ifid_instr);
            check("m_ifid_valid", ifid_valid, m_valid);
            check("m_stall_cnt", stall_cnt, m_scnt);
            check("m_flush_cnt", flush_cnt, m_fcnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        start = 0; stall = 0; flush = 0;
        rst_n = 0;
        #2;
        rst_n = 1;
        start = 1;
        step();   // IDLE -> RUN edge
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", ifid_valid, 1'b0);
        check("rst_ifid_instr", ifid_instr, 32'h0);
        check("rst_cnts", {stall_cnt, flush_cnt}, 64'h0);
        cmp_en = 1;

        // Scenario 1: sequential fetch
        step(); rst_n = 1; start = 1;
        step();
        check("s1_idle_edge_pc", pc, 32'h0);
        check("s1_idle_edge_valid", ifid_valid, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("s1_pc", pc, 32'(4 * k));
            check("s1_ifid_pc", ifid_pc, 32'(4 * k));
            check("s1_valid", ifid_valid, 1'b1);
            check("s1_instr", ifid_instr, mem_word(32'(4 * k - 4)));
        end

        // Scenario 2: 2-cycle stall at PC=8
        restart();
        step(); step();
        check("s2_pc8", pc, 32'h8);
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("s2_pc_frozen", pc, 32'h8);
            check("s2_ifid_frozen", ifid_pc, 32'h8);
            check("s2_instr_frozen", ifid_instr, mem_word(32'h4));
        end
        check("s2_stall_cnt", stall_cnt, 32'd2);
        stall = 0;
        step();
        check("s2_resume_pc", pc, 32'hC);
        check("s2_resume_instr", ifid_instr, mem_word(32'h8));

        // Scenario 3: flush to misaligned target at PC=12
        flush = 1; target = 32'h0000_0043;
        step();
        check("s3_pc", pc, 32'h40);
        check("s3_valid", ifid_valid, 1'b0);
        check("s3_instr", ifid_instr, 32'h0);
        check("s3_flush_cnt", flush_cnt, 32'd1);

        // Scenario 4: stall and flush together, then flush alone
        stall = 1; flush = 1; target = 32'h100;
        step();
        check("s4_pc_held", pc, 32'h40);
        check("s4_flush_cnt_held", flush_cnt, 32'd1);
        check("s4_stall_cnt", stall_cnt, 32'd3);
        stall = 0;
        step();
        check("s4_redirect", pc, 32'h100);
        check("s4_flush_cnt", flush_cnt, 32'd2);

        // Scenario 6: reset mid-RUN at PC=20
        target = 32'h10;
        step();
        flush = 0;
        step();
        check("s6_pc20", pc, 32'd20);
        #2;
        rst_n = 0;
        #1;
        check("s6_rst_pc", pc, 32'h0);
        check("s6_rst_cnts", {stall_cnt, flush_cnt}, 64'h0);
        check("s6_rst_valid", ifid_valid, 1'b0);
        start = 0;
        step(); rst_n = 1;
        step(); step();
        check("s6_idle_hold", pc, 32'h0);
        start = 1;
        step();
        check("s6_transition", pc, 32'h0);
        step();
        check("s6_first_fetch", pc, 32'h4);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 9) != 0);
            stall  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 4) == 0);
            target = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                #2; rst_n = 0; #1; rst_n = 1;
            end
            step();
        end
        start = 0; stall = 0; flush = 0;

        // Scenario 5 plus saturation on instance B
        check("b_rst_pc", b_pc, 32'hFFFF_FFFC);
        b_rst_n = 1; b_start = 1;
        step();
        step();
        check("b_wrap_pc", b_pc, 32'h0);
        check("b_wrap_ifid_pc", b_ifid_pc, 32'h0);
        check("b_wrap_valid", b_valid, 1'b1);
        check("b_wrap_instr", b_ifid_instr, mem_word(32'hFFFF_FFFC));
        b_stall = 1;
        for (int k = 0; k < 9; k++) step();
        check("b_stall_sat", b_scnt, 3'd7);
        check("b_stall_pc", b_pc, 32'h0);
        b_stall = 0; b_flush = 1; b_target = 32'h20;
        for (int k = 0; k < 9; k++) step();
        check("b_flush_sat", b_fcnt, 3'd7);
        check("b_flush_pc", b_pc, 32'h20);
        check("b_stall_kept", b_scnt, 3'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_stage
